// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
package rf_pkg;

  localparam int RF_DATAWIDTH = 64;
  localparam int RF_ADDRWIDTH = 2;

  typedef struct packed {
    logic [RF_ADDRWIDTH-1:0] addr;
    logic [RF_DATAWIDTH-1:0] data;
  } rf_wreq_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request ports and RF write port of the writeback arbiter.
interface rf_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int DATAWIDTH = RF_DATAWIDTH,
  parameter int ADDRWIDTH = RF_ADDRWIDTH
);

  logic                 req0_valid;
  logic                 req0_ready;
  logic [ADDRWIDTH-1:0] req0_addr;
  logic [DATAWIDTH-1:0] req0_data;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [ADDRWIDTH-1:0] req1_addr;
  logic [DATAWIDTH-1:0] req1_data;
  logic                 rf_hold;
  logic                 rf_wen;
  logic [ADDRWIDTH-1:0] rf_waddr;
  logic [DATAWIDTH-1:0] rf_wdata;
  logic                 grant_id;
  logic                 idle;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rf_hold,
    input  req0_ready, req1_ready,
    input  rf_wen, rf_waddr, rf_wdata, grant_id, idle
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rf_hold,
    output req0_ready, req1_ready,
    output rf_wen, rf_waddr, rf_wdata, grant_id, idle
  );

endinterface

// File: rtl/rf_wb_arbiter_chk.sv
// Protocol and invariant assertions for the writeback arbiter.
module rf_wb_arbiter_chk #(
  parameter int DATAWIDTH = 64,
  parameter int ADDRWIDTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 valid0,
  input logic                 ready0,
  input logic [ADDRWIDTH-1:0] addr0,
  input logic [DATAWIDTH-1:0] data0,
  input logic                 valid1,
  input logic                 ready1,
  input logic [ADDRWIDTH-1:0] addr1,
  input logic [DATAWIDTH-1:0] data1,
  input logic                 push0,
  input logic                 full0,
  input logic                 push1,
  input logic                 full1,
  input logic                 rf_hold,
  input logic                 rf_wen
);

  // A stalled request must stay valid and unchanged until it transfers.
  a_req0_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (valid0 && !ready0) |=> (valid0 && $stable(addr0) && $stable(data0)));

  a_req1_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (valid1 && !ready1) |=> (valid1 && $stable(addr1) && $stable(data1)));

  a_no_push_full0: assert property (@(posedge clk) disable iff (!rst_n) !(push0 && full0));
  a_no_push_full1: assert property (@(posedge clk) disable iff (!rst_n) !(push1 && full1));

  a_hold_blocks_write: assert property (@(posedge clk) disable iff (!rst_n)
    rf_hold |=> !rf_wen);

endmodule

// File: rtl/rf_wb_fifo.sv
// Synchronous in-order FIFO for one writeback requester.
module rf_wb_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Entry storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single RF write port, fed by two buffered
// writeback producers (port 0 ALU, port 1 load/host), with a registered write stage.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATAWIDTH  = RF_DATAWIDTH,
  parameter int ADDRWIDTH  = RF_ADDRWIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input logic            clk,
  input logic            rst_n,
  rf_wb_arbiter_if.slave bus
);

  localparam int ENTRY_W = ADDRWIDTH + DATAWIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ENTRY_W-1:0]   head0_s;
  logic [ENTRY_W-1:0]   head1_s;
  logic [CNT_W-1:0]     count0_s;
  logic [CNT_W-1:0]     count1_s;
  logic                 full0_s;
  logic                 full1_s;
  logic                 empty0_s;
  logic                 empty1_s;
  logic                 ready0_s;
  logic                 ready1_s;
  logic                 push0_s;
  logic                 push1_s;
  logic                 pop0_s;
  logic                 pop1_s;
  logic                 grant_valid_s;
  port_e                grant_port_s;
  logic [ENTRY_W-1:0]   grant_head_s;
  port_e                last_grant_r;
  logic                 rf_wen_r;
  logic [ADDRWIDTH-1:0] rf_waddr_r;
  logic [DATAWIDTH-1:0] rf_wdata_r;
  port_e                grant_id_r;

  // Ready depends only on occupancy so it never combinationally follows valid.
  assign ready0_s = (count0_s < DEPTH_C);
  assign ready1_s = (count1_s < DEPTH_C);
  assign push0_s  = bus.req0_valid & ready0_s;
  assign push1_s  = bus.req1_valid & ready1_s;

  rf_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0_s),
    .wdata ({bus.req0_addr, bus.req0_data}),
    .pop   (pop0_s),
    .rdata (head0_s),
    .count (count0_s),
    .full  (full0_s),
    .empty (empty0_s)
  );

  rf_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1_s),
    .wdata ({bus.req1_addr, bus.req1_data}),
    .pop   (pop1_s),
    .rdata (head1_s),
    .count (count1_s),
    .full  (full1_s),
    .empty (empty1_s)
  );

  // Grant selection on the FIFO heads; a contest goes to the port not granted last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = PORT0;
    if (bus.rf_hold) begin
      grant_valid_s = 1'b0;
    end else if (!empty0_s && !empty1_s) begin
      grant_valid_s = 1'b1;
      grant_port_s  = other_port(last_grant_r);
    end else if (!empty0_s) begin
      grant_valid_s = 1'b1;
      grant_port_s  = PORT0;
    end else if (!empty1_s) begin
      grant_valid_s = 1'b1;
      grant_port_s  = PORT1;
    end else begin
      grant_valid_s = 1'b0;
    end
  end

  assign pop0_s       = grant_valid_s && (grant_port_s == PORT0);
  assign pop1_s       = grant_valid_s && (grant_port_s == PORT1);
  assign grant_head_s = (grant_port_s == PORT1) ? head1_s : head0_s;

  // Round-robin history; reset to port 1 so port 0 wins the first contest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_r <= PORT1;
    end else if (grant_valid_s) begin
      last_grant_r <= grant_port_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Registered RF write stage; address, data and id hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= {ADDRWIDTH{1'b0}};
      rf_wdata_r <= {DATAWIDTH{1'b0}};
      grant_id_r <= PORT0;
    end else begin
      rf_wen_r <= grant_valid_s;
      if (grant_valid_s) begin
        rf_waddr_r <= grant_head_s[ENTRY_W-1 -: ADDRWIDTH];
        rf_wdata_r <= grant_head_s[DATAWIDTH-1:0];
        grant_id_r <= grant_port_s;
      end else begin
        rf_waddr_r <= rf_waddr_r;
        rf_wdata_r <= rf_wdata_r;
        grant_id_r <= grant_id_r;
      end
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.rf_wen     = rf_wen_r;
  assign bus.rf_waddr   = rf_waddr_r;
  assign bus.rf_wdata   = rf_wdata_r;
  assign bus.grant_id   = grant_id_r;
  assign bus.idle       = empty0_s & empty1_s & ~rf_wen_r;

  rf_wb_arbiter_chk #(
    .DATAWIDTH (DATAWIDTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid0  (bus.req0_valid),
    .ready0  (ready0_s),
    .addr0   (bus.req0_addr),
    .data0   (bus.req0_data),
    .valid1  (bus.req1_valid),
    .ready1  (ready1_s),
    .addr1   (bus.req1_addr),
    .data1   (bus.req1_data),
    .push0   (push0_s),
    .full0   (full0_s),
    .push1   (push1_s),
    .full1   (full1_s),
    .rf_hold (bus.rf_hold),
    .rf_wen  (rf_wen_r)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic
// compared against a queue-level model of the two producers and the write port.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int DW    = 64;
  localparam int AW    = 2;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

  rf_wb_arbiter #(
    .DATAWIDTH  (DW),
    .ADDRWIDTH  (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model state
  rf_wreq_t          q0[$];
  rf_wreq_t          q1[$];
  int                m_last;
  logic              m_wen;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_data;
  logic              m_gid;
  bit                m_acc0;
  bit                m_acc1;
  logic [DW-1:0]     m_rf   [4];
  logic [DW-1:0]     obs_rf [4];
  int                n_checks;
  int                n_errors;

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    bit       r0;
    bit       r1;
    int       g;
    rf_wreq_t e;
    r0 = (q0.size() < DEPTH);
    r1 = (q1.size() < DEPTH);
    m_acc0 = 1'b0;
    m_acc1 = 1'b0;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_last = 1;
      m_wen  = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_gid  = 1'b0;
    end else begin
      g = -1;
      if (!bus.rf_hold) begin
        if (q0.size() > 0 && q1.size() > 0) g = 1 - m_last;
        else if (q0.size() > 0)             g = 0;
        else if (q1.size() > 0)             g = 1;
      end
      m_wen = (g >= 0);
      if (g == 0) begin
        e = q0.pop_front();
        m_addr = e.addr; m_data = e.data; m_gid = 1'b0; m_last = 0;
      end else if (g == 1) begin
        e = q1.pop_front();
        m_addr = e.addr; m_data = e.data; m_gid = 1'b1; m_last = 1;
      end
      if (m_wen) m_rf[m_addr] = m_data;
      m_acc0 = bus.req0_valid && r0;
      m_acc1 = bus.req1_valid && r1;
      if (m_acc0) begin e.addr = bus.req0_addr; e.data = bus.req0_data; q0.push_back(e); end
      if (m_acc1) begin e.addr = bus.req1_addr; e.data = bus.req1_data; q1.push_back(e); end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (bus.rf_wen === 1'b1) obs_rf[bus.rf_waddr] = bus.rf_wdata;
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rf_hold    = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.rf_wen !== 1'b0) begin n_errors++; $display("FAIL reset_wen: got %b want 0", bus.rf_wen); end
    n_checks++; if (bus.rf_waddr !== 2'd0) begin n_errors++; $display("FAIL reset_waddr: got %0d want 0", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 64'd0) begin n_errors++; $display("FAIL reset_wdata: got %0h want 0", bus.rf_wdata); end
    n_checks++; if (bus.grant_id !== 1'b0) begin n_errors++; $display("FAIL reset_grant_id: got %b want 0", bus.grant_id); end
    n_checks++; if (bus.req0_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready0: got %b want 1", bus.req0_ready); end
    n_checks++; if (bus.req1_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready1: got %b want 1", bus.req1_ready); end
    n_checks++; if (bus.idle !== 1'b1) begin n_errors++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
  endtask

  task automatic test_single_write();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 2'd2;
    bus.req0_data  = 64'h0000_0000_DEAD_BEEF;
    tick();
    bus.req0_valid = 1'b0;
    n_checks++; if (bus.rf_wen !== 1'b0) begin n_errors++; $display("FAIL single_wen_n1: got %b want 0", bus.rf_wen); end
    n_checks++; if (bus.idle !== 1'b0) begin n_errors++; $display("FAIL single_idle_n1: got %b want 0", bus.idle); end
    tick();
    n_checks++; if (bus.rf_wen !== 1'b1) begin n_errors++; $display("FAIL single_wen_n2: got %b want 1", bus.rf_wen); end
    n_checks++; if (bus.rf_waddr !== 2'd2) begin n_errors++; $display("FAIL single_waddr: got %0d want 2", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 64'h0000_0000_DEAD_BEEF) begin n_errors++; $display("FAIL single_wdata: got %0h want deadbeef", bus.rf_wdata); end
    n_checks++; if (bus.grant_id !== 1'b0) begin n_errors++; $display("FAIL single_grant_id: got %b want 0", bus.grant_id); end
    tick();
    n_checks++; if (bus.idle !== 1'b1) begin n_errors++; $display("FAIL single_idle_after: got %b want 1", bus.idle); end
    n_checks++; if (bus.rf_wen !== 1'b0) begin n_errors++; $display("FAIL single_wen_after: got %b want 0", bus.rf_wen); end
  endtask

  task automatic test_back_to_back();
    int i0, i1, nw, first_c, last_c;
    logic [DW-1:0] exp_d;
    do_reset();
    i0 = 0; i1 = 0; nw = 0; first_c = -1; last_c = -1;
    bus.req0_valid = 1'b1; bus.req0_addr = 2'd0; bus.req0_data = {32'hA0A0_0000, 32'd0};
    bus.req1_valid = 1'b1; bus.req1_addr = 2'd3; bus.req1_data = {32'hB1B1_0000, 32'd0};
    for (int c = 0; c < 30; c++) begin
      tick();
      if (m_acc0) begin
        i0++;
        if (i0 < 4) begin bus.req0_addr = 2'(i0); bus.req0_data = {32'hA0A0_0000, 32'(i0)}; end
        else bus.req0_valid = 1'b0;
      end
      if (m_acc1) begin
        i1++;
        if (i1 < 4) begin bus.req1_addr = 2'(3 - i1); bus.req1_data = {32'hB1B1_0000, 32'(i1)}; end
        else bus.req1_valid = 1'b0;
      end
      if (bus.rf_wen === 1'b1) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        exp_d = (nw % 2 == 0) ? {32'hA0A0_0000, 32'(nw / 2)} : {32'hB1B1_0000, 32'(nw / 2)};
        n_checks++; if (bus.grant_id !== 1'(nw % 2)) begin n_errors++; $display("FAIL b2b_grant_id[%0d]: got %b want %0d", nw, bus.grant_id, nw % 2); end
        n_checks++; if (bus.rf_wdata !== exp_d) begin n_errors++; $display("FAIL b2b_wdata[%0d]: got %0h want %0h", nw, bus.rf_wdata, exp_d); end
        nw++;
      end
    end
    n_checks++; if (nw !== 8) begin n_errors++; $display("FAIL b2b_write_count: got %0d want 8", nw); end
    n_checks++; if (last_c - first_c + 1 !== 8) begin n_errors++; $display("FAIL b2b_no_gaps: span %0d want 8", last_c - first_c + 1); end
  endtask

  task automatic test_same_addr();
    int nw;
    logic [DW-1:0] d [2];
    logic          g [2];
    do_reset();
    nw = 0;
    bus.req0_valid = 1'b1; bus.req0_addr = 2'd1; bus.req0_data = 64'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 2'd1; bus.req1_data = 64'h22;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.rf_wen === 1'b1 && bus.rf_waddr === 2'd1) begin
        if (nw < 2) begin d[nw] = bus.rf_wdata; g[nw] = bus.grant_id; end
        nw++;
      end
      tick();
    end
    n_checks++; if (nw !== 2) begin n_errors++; $display("FAIL same_addr_count: got %0d want 2", nw); end
    n_checks++; if (g[0] !== 1'b0 || d[0] !== 64'h11) begin n_errors++; $display("FAIL same_addr_first: got port %b data %0h want port 0 data 11", g[0], d[0]); end
    n_checks++; if (g[1] !== 1'b1 || d[1] !== 64'h22) begin n_errors++; $display("FAIL same_addr_second: got port %b data %0h want port 1 data 22", g[1], d[1]); end
    n_checks++; if (obs_rf[1] !== 64'h22) begin n_errors++; $display("FAIL same_addr_final: got %0h want 22", obs_rf[1]); end
  endtask

  task automatic test_hold();
    do_reset();
    bus.rf_hold = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_addr = 2'd3; bus.req1_data = 64'hA;
    tick();
    bus.req1_addr = 2'd2; bus.req1_data = 64'hB;
    tick();
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_errors++; $display("FAIL hold_ready_full: got %b want 0", bus.req1_ready); end
    bus.req1_addr = 2'd1; bus.req1_data = 64'hC;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (bus.req1_ready !== 1'b0 || bus.rf_wen !== 1'b0) begin n_errors++; $display("FAIL hold_stall[%0d]: got ready %b wen %b want 0 0", c, bus.req1_ready, bus.rf_wen); end
    end
    bus.rf_hold = 1'b0;
    tick();
    n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_wdata !== 64'hA || bus.grant_id !== 1'b1) begin n_errors++; $display("FAIL hold_first_write: got wen %b data %0h id %b want 1 a 1", bus.rf_wen, bus.rf_wdata, bus.grant_id); end
    n_checks++; if (bus.req1_ready !== 1'b1) begin n_errors++; $display("FAIL hold_ready_recover: got %b want 1", bus.req1_ready); end
    tick();
    bus.req1_valid = 1'b0;
    n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_wdata !== 64'hB) begin n_errors++; $display("FAIL hold_second_write: got wen %b data %0h want 1 b", bus.rf_wen, bus.rf_wdata); end
    tick();
    n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_wdata !== 64'hC || bus.rf_waddr !== 2'd1) begin n_errors++; $display("FAIL hold_third_write: got wen %b data %0h addr %0d want 1 c 1", bus.rf_wen, bus.rf_wdata, bus.rf_waddr); end
    tick();
    n_checks++; if (bus.rf_wen !== 1'b0 || bus.idle !== 1'b1) begin n_errors++; $display("FAIL hold_drain: got wen %b idle %b want 0 1", bus.rf_wen, bus.idle); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rf_hold = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 2'd0; bus.req0_data = 64'h51;
    bus.req1_valid = 1'b1; bus.req1_addr = 2'd1; bus.req1_data = 64'h61;
    tick();
    bus.req0_data = 64'h52;
    bus.req1_data = 64'h62;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n_checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin n_errors++; $display("FAIL mid_full: got ready %b %b want 0 0", bus.req0_ready, bus.req1_ready); end
    rst_n = 1'b0;
    bus.rf_hold = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (bus.rf_wen !== 1'b0) begin n_errors++; $display("FAIL mid_wen: got %b want 0", bus.rf_wen); end
    n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin n_errors++; $display("FAIL mid_ready: got %b %b want 1 1", bus.req0_ready, bus.req1_ready); end
    n_checks++; if (bus.idle !== 1'b1) begin n_errors++; $display("FAIL mid_idle: got %b want 1", bus.idle); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (bus.rf_wen !== 1'b0) begin n_errors++; $display("FAIL mid_stale[%0d]: got wen %b want 0", c, bus.rf_wen); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.rf_hold = ($urandom_range(0, 9) < 2);
      if (!(bus.req0_valid && !m_acc0)) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_addr  = 2'($urandom_range(0, 3));
        bus.req0_data  = {$urandom(), $urandom()};
      end
      if (!(bus.req1_valid && !m_acc1)) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_addr  = 2'($urandom_range(0, 3));
        bus.req1_data  = {$urandom(), $urandom()};
      end
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      tick();
      rst_n = 1'b1;
      n_checks++; if (bus.rf_wen !== m_wen) begin n_errors++; $display("FAIL rnd_wen@%0d: got %b want %b", c, bus.rf_wen, m_wen); end
      n_checks++; if (bus.rf_waddr !== m_addr) begin n_errors++; $display("FAIL rnd_waddr@%0d: got %0d want %0d", c, bus.rf_waddr, m_addr); end
      n_checks++; if (bus.rf_wdata !== m_data) begin n_errors++; $display("FAIL rnd_wdata@%0d: got %0h want %0h", c, bus.rf_wdata, m_data); end
      n_checks++; if (bus.grant_id !== m_gid) begin n_errors++; $display("FAIL rnd_grant_id@%0d: got %b want %b", c, bus.grant_id, m_gid); end
      n_checks++; if (bus.req0_ready !== (q0.size() < DEPTH)) begin n_errors++; $display("FAIL rnd_ready0@%0d: got %b want %b", c, bus.req0_ready, q0.size() < DEPTH); end
      n_checks++; if (bus.req1_ready !== (q1.size() < DEPTH)) begin n_errors++; $display("FAIL rnd_ready1@%0d: got %b want %b", c, bus.req1_ready, q1.size() < DEPTH); end
      n_checks++; if (bus.idle !== (q0.size() == 0 && q1.size() == 0 && !m_wen)) begin n_errors++; $display("FAIL rnd_idle@%0d: got %b", c, bus.idle); end
    end
    for (int a = 0; a < 4; a++) begin
      n_checks++; if (obs_rf[a] !== m_rf[a]) begin n_errors++; $display("FAIL rnd_rf[%0d]: got %0h want %0h", a, obs_rf[a], m_rf[a]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_last = 1; m_wen = 1'b0; m_addr = '0; m_data = '0; m_gid = 1'b0;
    m_acc0 = 1'b0; m_acc1 = 1'b0;
    for (int a = 0; a < 4; a++) begin m_rf[a] = '0; obs_rf[a] = '0; end
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.rf_hold = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_same_addr();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
